// File: rtl/i2c_mux_ctrl.sv
// i2c_mux_ctrl: sequencing controller for the PCA9548 8-channel I2C switch.
//
// Holds the switch in reset after power-up (and again on s_reset_req), then
// accepts channel-select requests and turns each one into a single
// start+write+stop command with one data byte for the shared I2C master.
// cur_mask tracks the mask the switch is known to hold.
//
// Optional build macro: I2C_MUX_READBACK_EN. When it is defined, every good
// write is followed by a start+read+stop of the control register, and
// cur_mask is only updated if the byte read back matches.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   s_sel_mask/valid/ready/force       channel-select request
//   s_reset_req                        pulse: re-run the mux reset sequence
//   m_axis_cmd_*                       command word to the I2C master
//   m_axis_tx_*                        write byte to the I2C master
//   s_axis_rx_* (readback build only)  read byte from the I2C master
//   i2c_busy, i2c_missed_ack           status from the I2C master
//   i2c_mux_reset_n                    switch reset pin, active low
//   cur_mask, ready, error             status
//
// state      | meaning
// -----------+--------------------------------------------------------------
// RST_HOLD   | mux reset pin low for RESET_CYCLES, cur_mask forced to 0
// SETTLE     | reset released, wait SETTLE_CYCLES before first transaction
// IDLE       | accept select requests / reset requests
// CMD        | present write command word until accepted
// DATA       | present mask byte until accepted
// WAIT_START | wait for the master to go busy (bounded)
// WAIT_DONE  | collect missed-ack while busy, finish when busy falls
// CMD_RD     | (readback) present read command word until accepted
// RD_WAIT    | (readback) take one rx byte, finish when busy falls

module i2c_mux_ctrl #(
    parameter logic [6:0]  MUX_ADDR      = 7'h74,
    parameter int unsigned RESET_CYCLES  = 1250,
    parameter int unsigned SETTLE_CYCLES = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_sel_mask,
    input  logic        s_sel_valid,
    output logic        s_sel_ready,
    input  logic        s_sel_force,
    input  logic        s_reset_req,
    output logic [11:0] m_axis_cmd_tdata,
    output logic        m_axis_cmd_tvalid,
    input  logic        m_axis_cmd_tready,
    output logic [7:0]  m_axis_tx_tdata,
    output logic        m_axis_tx_tvalid,
    input  logic        m_axis_tx_tready,
    output logic        m_axis_tx_tlast,
`ifdef I2C_MUX_READBACK_EN
    input  logic [7:0]  s_axis_rx_tdata,
    input  logic        s_axis_rx_tvalid,
    output logic        s_axis_rx_tready,
`endif
    input  logic        i2c_busy,
    input  logic        i2c_missed_ack,
    output logic        i2c_mux_reset_n,
    output logic [7:0]  cur_mask,
    output logic        ready,
    output logic        error
);

    // {stop, write_multiple, write, read, start, addr}
    localparam logic [11:0] CMD_WR_WORD = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, MUX_ADDR};
    localparam logic [11:0] CMD_RD_WORD = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, MUX_ADDR};
    localparam logic [15:0] RST_LAST    = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] SET_LAST    = 16'(SETTLE_CYCLES - 1);
    // Counter restarts at 0 on state entry, so leaving at 0xFFFE bounds the
    // wait to 65535 cycles.
    localparam logic [15:0] TMO_LAST    = 16'hFFFE;

    typedef enum logic [3:0] {
        ST_RST_HOLD, ST_SETTLE, ST_IDLE, ST_CMD, ST_DATA,
        ST_WAIT_START, ST_WAIT_DONE, ST_CMD_RD, ST_RD_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  cur_mask_q, cur_mask_d;
    logic        error_q, error_d;
    logic        nack_q, nack_d;
    logic        pend_q, pend_d;
    logic        cnt_clr;
`ifdef I2C_MUX_READBACK_EN
    logic [7:0]  rx_q, rx_d;
    logic        rx_got_q, rx_got_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RST_HOLD;
            cnt_q      <= '0;
            mask_q     <= '0;
            cur_mask_q <= '0;
            error_q    <= 1'b0;
            nack_q     <= 1'b0;
            pend_q     <= 1'b0;
`ifdef I2C_MUX_READBACK_EN
            rx_q       <= '0;
            rx_got_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            cur_mask_q <= cur_mask_d;
            error_q    <= error_d;
            nack_q     <= nack_d;
            pend_q     <= pend_d;
`ifdef I2C_MUX_READBACK_EN
            rx_q       <= rx_d;
            rx_got_q   <= rx_got_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        cnt_clr    = 1'b0;
        mask_d     = mask_q;
        cur_mask_d = cur_mask_q;
        error_d    = error_q;
        nack_d     = nack_q;
        // A reset request mid-transaction is remembered until the current
        // handshake completes.
        pend_d     = pend_q | s_reset_req;
`ifdef I2C_MUX_READBACK_EN
        rx_d       = rx_q;
        rx_got_d   = rx_got_q;
`endif
        case (state_q)
            ST_RST_HOLD: begin
                pend_d = 1'b0;
                if (s_reset_req)            cnt_clr = 1'b1;
                else if (cnt_q == RST_LAST) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                pend_d = 1'b0;
                if (s_reset_req)            state_d = ST_RST_HOLD;
                else if (cnt_q == SET_LAST) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                pend_d = 1'b0;
                if (s_reset_req) begin
                    state_d = ST_RST_HOLD;
                end else if (s_sel_valid) begin
                    mask_d = s_sel_mask;
                    if ((s_sel_mask != cur_mask_q) || s_sel_force) begin
                        error_d = 1'b0;
                        nack_d  = 1'b0;
                        state_d = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                if (m_axis_cmd_tready) state_d = pend_d ? ST_RST_HOLD : ST_DATA;
            end
            ST_DATA: begin
                if (m_axis_tx_tready) state_d = pend_d ? ST_RST_HOLD : ST_WAIT_START;
            end
            ST_WAIT_START: begin
                nack_d = nack_q | (i2c_busy & i2c_missed_ack);
                if (pend_d) begin
                    state_d = ST_RST_HOLD;
                end else if (i2c_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                nack_d = nack_q | (i2c_busy & i2c_missed_ack);
                if (pend_d) begin
                    state_d = ST_RST_HOLD;
                end else if (!i2c_busy) begin
                    if (nack_q) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
`ifdef I2C_MUX_READBACK_EN
                        state_d = ST_CMD_RD;
`else
                        cur_mask_d = mask_q;
                        state_d    = ST_IDLE;
`endif
                    end
                end
            end
`ifdef I2C_MUX_READBACK_EN
            ST_CMD_RD: begin
                rx_got_d = 1'b0;
                if (m_axis_cmd_tready) state_d = pend_d ? ST_RST_HOLD : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                nack_d = nack_q | (i2c_busy & i2c_missed_ack);
                if (s_axis_rx_tvalid && !rx_got_q) begin
                    rx_d     = s_axis_rx_tdata;
                    rx_got_d = 1'b1;
                end
                if (pend_d) begin
                    state_d = ST_RST_HOLD;
                end else if (rx_got_q && !i2c_busy) begin
                    if (nack_q || (rx_q != mask_q)) error_d    = 1'b1;
                    else                            cur_mask_d = mask_q;
                    state_d = ST_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_RST_HOLD;
        endcase
        if (cnt_clr || (state_d != state_q)) cnt_d = '0;
        // The switch powers up with all channels off.
        if (state_d == ST_RST_HOLD) cur_mask_d = '0;
    end

    always_comb begin
        i2c_mux_reset_n   = (state_q != ST_RST_HOLD);
        ready             = (state_q == ST_IDLE);
        // A simultaneous reset request wins, so the select is not accepted.
        s_sel_ready       = (state_q == ST_IDLE) && !s_reset_req;
        m_axis_cmd_tvalid = (state_q == ST_CMD) || (state_q == ST_CMD_RD);
        m_axis_cmd_tdata  = (state_q == ST_CMD_RD) ? CMD_RD_WORD : CMD_WR_WORD;
        m_axis_tx_tvalid  = (state_q == ST_DATA);
        m_axis_tx_tdata   = mask_q;
        m_axis_tx_tlast   = 1'b1;
`ifdef I2C_MUX_READBACK_EN
        s_axis_rx_tready  = (state_q == ST_RD_WAIT);
`endif
        cur_mask          = cur_mask_q;
        error             = error_q;
    end

endmodule

// File: tb/tb_i2c_mux_ctrl.sv
module tb_i2c_mux_ctrl;

    localparam logic [11:0] CMD_WR = 12'hAF4;
    localparam logic [11:0] CMD_RD = 12'h9F4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_sel_mask = '0;
    logic        s_sel_valid = 1'b0;
    logic        s_sel_ready;
    logic        s_sel_force = 1'b0;
    logic        s_reset_req = 1'b0;
    logic [11:0] m_axis_cmd_tdata;
    logic        m_axis_cmd_tvalid;
    logic        m_axis_cmd_tready = 1'b0;
    logic [7:0]  m_axis_tx_tdata;
    logic        m_axis_tx_tvalid;
    logic        m_axis_tx_tready = 1'b0;
    logic        m_axis_tx_tlast;
`ifdef I2C_MUX_READBACK_EN
    logic [7:0]  s_axis_rx_tdata = '0;
    logic        s_axis_rx_tvalid = 1'b0;
    logic        s_axis_rx_tready;
`endif
    logic        i2c_busy = 1'b0;
    logic        i2c_missed_ack = 1'b0;
    logic        i2c_mux_reset_n;
    logic [7:0]  cur_mask;
    logic        ready;
    logic        error;

    int checks = 0;
    int errors = 0;

    always #4 clk = ~clk;

    i2c_mux_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_sel_mask        (s_sel_mask),
        .s_sel_valid       (s_sel_valid),
        .s_sel_ready       (s_sel_ready),
        .s_sel_force       (s_sel_force),
        .s_reset_req       (s_reset_req),
        .m_axis_cmd_tdata  (m_axis_cmd_tdata),
        .m_axis_cmd_tvalid (m_axis_cmd_tvalid),
        .m_axis_cmd_tready (m_axis_cmd_tready),
        .m_axis_tx_tdata   (m_axis_tx_tdata),
        .m_axis_tx_tvalid  (m_axis_tx_tvalid),
        .m_axis_tx_tready  (m_axis_tx_tready),
        .m_axis_tx_tlast   (m_axis_tx_tlast),
`ifdef I2C_MUX_READBACK_EN
        .s_axis_rx_tdata   (s_axis_rx_tdata),
        .s_axis_rx_tvalid  (s_axis_rx_tvalid),
        .s_axis_rx_tready  (s_axis_rx_tready),
`endif
        .i2c_busy          (i2c_busy),
        .i2c_missed_ack    (i2c_missed_ack),
        .i2c_mux_reset_n   (i2c_mux_reset_n),
        .cur_mask          (cur_mask),
        .ready             (ready),
        .error             (error)
    );

    typedef struct {
        logic [7:0] mask;
        logic       frc;
        logic       nack;
        int         stall;
        logic       issue;
        logic [7:0] exp_cur;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int bound, output int n);
        n = 0;
        while (!ready && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic count_mux_reset(output int n);
        n = 0;
        while (!i2c_mux_reset_n && n < 5000) begin
            tick();
            n++;
        end
    endtask

    // One select request; if it issues, drive the master side through a
    // full write (and readback when built with it).
    task automatic xact(input string tag, input logic [7:0] mask, input logic frc,
                        input logic nack, input int stall, input logic [7:0] rx_byte,
                        input logic issue);
        int   n;
        logic ok;
        s_sel_mask  = mask;
        s_sel_force = frc;
        s_sel_valid = 1'b1;
        chk({tag, ".sel_ready"}, 32'(s_sel_ready), 32'd1);
        tick();
        s_sel_valid = 1'b0;
        s_sel_force = 1'b0;
        if (!issue) begin
            chk({tag, ".noop_cmd_tvalid"}, 32'(m_axis_cmd_tvalid), 32'd0);
            chk({tag, ".noop_sel_ready"}, 32'(s_sel_ready), 32'd1);
            return;
        end
        ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (!(m_axis_cmd_tvalid && m_axis_cmd_tdata == CMD_WR)) ok = 1'b0;
            tick();
        end
        chk({tag, ".cmd_stall_stable"}, 32'(ok), 32'd1);
        chk({tag, ".cmd"}, {19'd0, m_axis_cmd_tvalid, m_axis_cmd_tdata}, {19'd0, 1'b1, CMD_WR});
        m_axis_cmd_tready = 1'b1;
        tick();
        m_axis_cmd_tready = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (!(m_axis_tx_tvalid && m_axis_tx_tdata == mask)) ok = 1'b0;
            tick();
        end
        chk({tag, ".tx_stall_stable"}, 32'(ok), 32'd1);
        chk({tag, ".tx"}, {22'd0, m_axis_tx_tvalid, m_axis_tx_tlast, m_axis_tx_tdata},
            {22'd0, 1'b1, 1'b1, mask});
        m_axis_tx_tready = 1'b1;
        tick();
        m_axis_tx_tready = 1'b0;
        tick();
        tick();
        i2c_busy = 1'b1;
        tick();
        i2c_missed_ack = nack;
        tick();
        i2c_missed_ack = 1'b0;
        tick();
        i2c_busy = 1'b0;
`ifdef I2C_MUX_READBACK_EN
        if (!nack) begin
            tick();
            chk({tag, ".rd_cmd"}, {19'd0, m_axis_cmd_tvalid, m_axis_cmd_tdata}, {19'd0, 1'b1, CMD_RD});
            m_axis_cmd_tready = 1'b1;
            tick();
            m_axis_cmd_tready = 1'b0;
            i2c_busy = 1'b1;
            tick();
            chk({tag, ".rx_tready"}, 32'(s_axis_rx_tready), 32'd1);
            s_axis_rx_tvalid = 1'b1;
            s_axis_rx_tdata  = rx_byte;
            tick();
            s_axis_rx_tvalid = 1'b0;
            tick();
            i2c_busy = 1'b0;
        end
`endif
        wait_ready(50, n);
        chk({tag, ".done"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int n;

        //            mask   frc   nack  stall issue exp_cur exp_err
        vecs[0] = '{8'h10, 1'b0, 1'b0, 5, 1'b1, 8'h10, 1'b0};
        vecs[1] = '{8'h10, 1'b0, 1'b0, 0, 1'b0, 8'h10, 1'b0};
        vecs[2] = '{8'h10, 1'b1, 1'b0, 0, 1'b1, 8'h10, 1'b0};
        vecs[3] = '{8'h01, 1'b0, 1'b1, 1, 1'b1, 8'h10, 1'b1};
        vecs[4] = '{8'h01, 1'b0, 1'b0, 0, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 0, 1'b1, 8'h01, 1'b1};
        vecs[6] = '{8'h01, 1'b0, 1'b0, 0, 1'b0, 8'h01, 1'b1};
        vecs[7] = '{8'hFF, 1'b0, 1'b0, 2, 1'b1, 8'hFF, 1'b0};

        // Reset state
        #20;
        chk("rst.mux_reset_n", 32'(i2c_mux_reset_n), 32'd0);
        chk("rst.status", {27'd0, ready, error, s_sel_ready, m_axis_cmd_tvalid, m_axis_tx_tvalid}, 32'd0);
        chk("rst.cur_mask", 32'(cur_mask), 32'd0);

        // Power-up sequence
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_mux_reset(n);
        chk("pwr.reset_cycles", 32'(n), 32'd1250);
        wait_ready(200, n);
        chk("pwr.settle_cycles", 32'(n), 32'd125);
        chk("pwr.cur_mask", 32'(cur_mask), 32'd0);
        chk("pwr.error", 32'(error), 32'd0);

        // Table-driven select vectors
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            xact(tag, vecs[i].mask, vecs[i].frc, vecs[i].nack, vecs[i].stall,
                 vecs[i].mask, vecs[i].issue);
            chk({tag, ".cur_mask"}, 32'(cur_mask), 32'(vecs[i].exp_cur));
            chk({tag, ".error"}, 32'(error), 32'(vecs[i].exp_err));
        end

        // Reset request in DATA with tx stalled
        s_sel_mask  = 8'h20;
        s_sel_valid = 1'b1;
        tick();
        s_sel_valid = 1'b0;
        m_axis_cmd_tready = 1'b1;
        tick();
        m_axis_cmd_tready = 1'b0;
        s_reset_req = 1'b1;
        tick();
        s_reset_req = 1'b0;
        tick();
        chk("rreq.tx_held", {30'd0, m_axis_tx_tvalid, i2c_mux_reset_n}, {30'd0, 1'b1, 1'b1});
        m_axis_tx_tready = 1'b1;
        tick();
        m_axis_tx_tready = 1'b0;
        chk("rreq.tx_dropped", 32'(m_axis_tx_tvalid), 32'd0);
        chk("rreq.cur_mask", 32'(cur_mask), 32'd0);
        count_mux_reset(n);
        chk("rreq.reset_cycles", 32'(n), 32'd1250);
        wait_ready(200, n);
        chk("rreq.settle_cycles", 32'(n), 32'd125);

        // WAIT_START timeout: busy never rises
        s_sel_mask  = 8'h40;
        s_sel_valid = 1'b1;
        tick();
        s_sel_valid = 1'b0;
        m_axis_cmd_tready = 1'b1;
        tick();
        m_axis_cmd_tready = 1'b0;
        m_axis_tx_tready = 1'b1;
        tick();
        m_axis_tx_tready = 1'b0;
        wait_ready(70000, n);
        chk("tmo.cycles", 32'(n), 32'd65535);
        chk("tmo.error", 32'(error), 32'd1);
        chk("tmo.cur_mask", 32'(cur_mask), 32'd0);
        xact("tmo_recover", 8'h40, 1'b0, 1'b0, 0, 8'h40, 1'b1);
        chk("tmo_recover.cur_mask", 32'(cur_mask), 32'h40);
        chk("tmo_recover.error", 32'(error), 32'd0);

`ifdef I2C_MUX_READBACK_EN
        xact("rb_bad", 8'h04, 1'b0, 1'b0, 0, 8'h02, 1'b1);
        chk("rb_bad.error", 32'(error), 32'd1);
        chk("rb_bad.cur_mask", 32'(cur_mask), 32'h40);
        xact("rb_good", 8'h04, 1'b0, 1'b0, 0, 8'h04, 1'b1);
        chk("rb_good.error", 32'(error), 32'd0);
        chk("rb_good.cur_mask", 32'(cur_mask), 32'h04);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
